// File: rtl/stream_stage_sched.sv
`default_nettype none
// ============================================================================
// stream_stage_sched : global tile scheduler over NUM_STAGE local controllers
// Revision: 1.0
// ============================================================================
module stream_stage_sched #(
  parameter int unsigned NUM_STAGE = 3,
  parameter int unsigned NUM_TILE  = 4,
  parameter int unsigned BUF_DEPTH = 1,
  parameter int unsigned TW        = $clog2(NUM_TILE + 1)
) (
  input  logic                    clk_i,
  input  logic                    rst_i,
  input  logic                    start_i,
  input  logic [NUM_STAGE-1:0]    stage_done_i,
  output logic [NUM_STAGE-1:0]    stage_start_o,
  output logic [NUM_STAGE*TW-1:0] stage_tile_o,
  output logic                    busy_o,
  output logic                    done_o,
  output logic                    err_o
);

  localparam logic [TW-1:0] C_NUM_TILE = TW'(NUM_TILE);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  state_t               r_state;
  logic [NUM_STAGE-1:0] r_busy;
  logic [TW-1:0]        r_iss  [NUM_STAGE];
  logic [TW-1:0]        r_comp [NUM_STAGE];
  logic [TW-1:0]        r_tile [NUM_STAGE];
  logic [NUM_STAGE-1:0] w_issue;

  for (genvar s = 0; s < NUM_STAGE; s++) begin : g_stage
    logic w_in_ok;
    logic w_out_ok;

    if (s == 0) begin : g_first
      assign w_in_ok = 1'b1;
    end else begin : g_dep
      assign w_in_ok = r_comp[s-1] > r_iss[s];
    end

    // Downstream has started everything it was handed, minus what still sits in the buffer.
    if (s == NUM_STAGE - 1) begin : g_last
      assign w_out_ok = 1'b1;
    end else begin : g_buf
      assign w_out_ok = (32'(r_iss[s]) - 32'(r_iss[s+1])) < BUF_DEPTH;
    end

    assign w_issue[s] = (r_state == ST_RUN) && !r_busy[s] &&
                        (r_iss[s] < C_NUM_TILE) && w_in_ok && w_out_ok;

    assign stage_tile_o[s*TW +: TW] = r_tile[s];
  end

  assign busy_o = (r_state != ST_IDLE);

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_state       <= ST_IDLE;
      r_busy        <= '0;
      stage_start_o <= '0;
      done_o        <= 1'b0;
      err_o         <= 1'b0;
      for (int s = 0; s < NUM_STAGE; s++) begin
        r_iss[s]  <= '0;
        r_comp[s] <= '0;
        r_tile[s] <= '0;
      end
    end else begin
      stage_start_o <= '0;
      done_o        <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (start_i) begin
            r_state <= ST_RUN;
            r_busy  <= '0;
            err_o   <= 1'b0;
            for (int s = 0; s < NUM_STAGE; s++) begin
              r_iss[s]  <= '0;
              r_comp[s] <= '0;
            end
          end
        end
        ST_RUN: begin
          if (r_comp[NUM_STAGE-1] == C_NUM_TILE) begin
            r_state <= ST_DONE;
            done_o  <= 1'b1;
          end
          // Issue needs !busy and a valid done needs busy, so both never hit one stage.
          for (int s = 0; s < NUM_STAGE; s++) begin
            if (stage_done_i[s]) begin
              if (r_busy[s]) begin
                r_busy[s] <= 1'b0;
                if (r_comp[s] < C_NUM_TILE) begin
                  r_comp[s] <= r_comp[s] + TW'(1);
                end
              end else begin
                err_o <= 1'b1;
              end
            end
            if (w_issue[s]) begin
              stage_start_o[s] <= 1'b1;
              r_tile[s]        <= r_iss[s];
              r_iss[s]         <= r_iss[s] + TW'(1);
              r_busy[s]        <= 1'b1;
            end
          end
        end
        ST_DONE: r_state <= ST_IDLE;
        default: r_state <= ST_IDLE;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_stream_stage_sched.sv
`default_nettype none
// tb_stream_stage_sched: scheduler checked cycle-by-cycle against a rule-level reference,
// plus job-level tile order, dependency, back-pressure and a 1-stage minimum-gap instance.
module tb_stream_stage_sched;

  localparam int NS = 3;
  localparam int NT = 4;
  localparam int BD = 1;
  localparam int TW = 3;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              start = 1'b0;
  logic [NS-1:0]     stage_done = '0;
  logic [NS-1:0]     stage_start;
  logic [NS*TW-1:0]  stage_tile;
  logic              busy, done, err;

  logic              s_start = 1'b0;
  logic              s_done = 1'b0;
  logic              s_stage_start;
  logic [1:0]        s_tile;
  logic              s_busy, s_doneo, s_err;

  always #5 clk = ~clk;

  stream_stage_sched dut (
    .clk_i(clk), .rst_i(rst), .start_i(start), .stage_done_i(stage_done),
    .stage_start_o(stage_start), .stage_tile_o(stage_tile),
    .busy_o(busy), .done_o(done), .err_o(err)
  );

  stream_stage_sched #(.NUM_STAGE(1), .NUM_TILE(2)) u_small (
    .clk_i(clk), .rst_i(rst), .start_i(s_start), .stage_done_i(s_done),
    .stage_start_o(s_stage_start), .stage_tile_o(s_tile),
    .busy_o(s_busy), .done_o(s_doneo), .err_o(s_err)
  );

  int n_total = 0;
  int n_bad   = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, exp, $time);
    end
  endtask

  // Reference: job phase plus started/completed tile counts per stage.
  int            m_phase;   // 0 idle, 1 running, 2 finishing
  int            m_iss  [NS];
  int            m_comp [NS];
  int            m_tile [NS];
  bit            m_busy [NS];
  bit            m_err;
  logic [NS-1:0] exp_start;
  logic          exp_done;

  task automatic model_reset();
    m_phase = 0; m_err = 1'b0; exp_start = '0; exp_done = 1'b0;
    for (int s = 0; s < NS; s++) begin
      m_iss[s] = 0; m_comp[s] = 0; m_tile[s] = 0; m_busy[s] = 1'b0;
    end
  endtask

  task automatic model_step(input logic st, input logic [NS-1:0] dn);
    bit can [NS];
    exp_start = '0;
    exp_done  = 1'b0;
    if (m_phase == 0) begin
      if (st) begin
        m_phase = 1; m_err = 1'b0;
        for (int s = 0; s < NS; s++) begin
          m_iss[s] = 0; m_comp[s] = 0; m_busy[s] = 1'b0;
        end
      end
    end else if (m_phase == 1) begin
      if (m_comp[NS-1] == NT) begin
        m_phase = 2; exp_done = 1'b1;
      end
      for (int s = 0; s < NS; s++)
        can[s] = !m_busy[s] && (m_iss[s] < NT) &&
                 ((s == 0) ? 1'b1 : (m_comp[s-1] > m_iss[s])) &&
                 ((s == NS-1) ? 1'b1 : (m_iss[s] - m_iss[s+1] < BD));
      for (int s = 0; s < NS; s++) begin
        if (dn[s]) begin
          if (m_busy[s]) begin
            m_busy[s] = 1'b0;
            if (m_comp[s] < NT) m_comp[s]++;
          end else begin
            m_err = 1'b1;
          end
        end
        if (can[s]) begin
          exp_start[s] = 1'b1; m_tile[s] = m_iss[s]; m_iss[s]++; m_busy[s] = 1'b1;
        end
      end
    end else begin
      m_phase = 0;
    end
  endtask

  function automatic logic [NS*TW-1:0] pack_tiles();
    logic [NS*TW-1:0] v;
    for (int s = 0; s < NS; s++) v[s*TW +: TW] = TW'(m_tile[s]);
    return v;
  endfunction

  // Inputs drive the current cycle; outputs of the following cycle are compared.
  task automatic tick(input logic st, input logic [NS-1:0] dn);
    start = st;
    stage_done = dn;
    model_step(st, dn);
    @(posedge clk); #1;
    chk("start_pulse", stage_start, exp_start);
    chk("tile_out", stage_tile, pack_tiles());
    chk("busy", busy, m_phase != 0);
    chk("done", done, exp_done);
    chk("err", err, m_err);
  endtask

  task automatic reset_now();
    #2;
    rst = 1'b1; start = 1'b0; stage_done = '0;
    #1;
    chk("rst_start", stage_start, 0);
    chk("rst_tile", stage_tile, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_err", err, 0);
    model_reset();
    @(posedge clk); #1;
    rst = 1'b0;
    repeat (3) tick(1'b0, '0);
  endtask

  // mode 0 nominal, 1 random latency + spurious dones + start noise, 2 stage 2 stalled, 3 start held
  task automatic run_job(input int mode);
    int due [NS];
    int due_tile [NS];
    int cnt [NS];
    int done_cyc [NS][NT];
    int n_done;
    int limit;
    logic st;
    logic [NS-1:0] dn;
    for (int s = 0; s < NS; s++) begin
      due[s] = -1; due_tile[s] = 0; cnt[s] = 0;
      for (int k = 0; k < NT; k++) done_cyc[s][k] = 100000;
    end
    n_done = 0;
    limit = (mode == 2) ? 40 : 200;
    for (int cyc = 0; cyc < limit; cyc++) begin
      dn = '0;
      for (int s = 0; s < NS; s++)
        if (due[s] == cyc) begin
          dn[s] = 1'b1; done_cyc[s][due_tile[s]] = cyc; due[s] = -1;
        end
      if (mode == 1 && cyc == 1) dn[1] = 1'b1;
      if (mode == 1 && !dn[1] && m_phase == 1 && !m_busy[1] && $urandom_range(0, 15) == 0)
        dn[1] = 1'b1;
      st = (cyc == 0) || (mode == 3) ||
           (mode == 1 && m_phase == 1 && $urandom_range(0, 3) == 0);
      tick(st, dn);
      for (int s = 0; s < NS; s++)
        if (stage_start[s]) begin
          if (cnt[s] < NT) begin
            chk("tile_order", stage_tile[s*TW +: TW], cnt[s]);
            if (s > 0) chk("dep_gap", (cyc + 1 >= done_cyc[s-1][cnt[s]] + 2), 1);
            due_tile[s] = cnt[s];
          end else begin
            chk("extra_start", cnt[s] + 1, NT);
          end
          cnt[s]++;
          if (!(mode == 2 && s == NS-1))
            due[s] = cyc + 1 + ((mode == 1) ? int'($urandom_range(1, 4)) : 3);
        end
      if (done) n_done++;
      if (n_done > 0 && mode != 2) break;
    end
    if (mode == 2) begin
      chk("bp_stage0", cnt[0], 3);
      chk("bp_stage1", cnt[1], 2);
      chk("bp_stage2", cnt[2], 1);
      chk("bp_no_done", n_done, 0);
    end else begin
      chk("job_done_count", n_done, 1);
      for (int s = 0; s < NS; s++) chk("tiles_per_stage", cnt[s], NT);
    end
    if (mode == 3) begin
      tick(1'b1, '0);
      chk("idle_after_done", busy, 0);
      tick(1'b1, '0);
      chk("restart_held_start", busy, 1);
      tick(1'b0, '0);
    end else if (mode != 2) begin
      tick(1'b0, '0);
      tick(1'b0, '0);
    end
  endtask

  task automatic min_gap_test();
    int st_cyc[$];
    int tiles[$];
    int dcyc;
    logic prev;
    dcyc = -1;
    prev = 1'b0;
    s_start = 1'b1;
    for (int k = 1; k <= 12; k++) begin
      @(posedge clk); #1;
      if (s_stage_start) begin
        st_cyc.push_back(k);
        tiles.push_back(int'(s_tile));
      end
      if (s_doneo && dcyc < 0) dcyc = k;
      s_start = 1'b0;
      s_done = prev;
      prev = s_stage_start;
    end
    s_done = 1'b0;
    chk("mg_start_count", st_cyc.size(), 2);
    while (st_cyc.size() < 2) begin
      st_cyc.push_back(-1);
      tiles.push_back(-1);
    end
    chk("mg_start0_cycle", st_cyc[0], 2);
    chk("mg_start0_tile", tiles[0], 0);
    chk("mg_start1_cycle", st_cyc[1], 5);
    chk("mg_start1_tile", tiles[1], 1);
    chk("mg_done_cycle", dcyc, 8);
    chk("mg_idle_after", s_busy, 0);
    chk("mg_no_err", s_err, 0);
  endtask

  initial begin
    model_reset();
    @(posedge clk); #1;
    chk("init_start", stage_start, 0);
    chk("init_tile", stage_tile, 0);
    chk("init_busy", busy, 0);
    chk("init_done", done, 0);
    chk("init_err", err, 0);
    rst = 1'b0;
    repeat (2) tick(1'b0, '0);

    run_job(0);

    tick(1'b1, '0);
    repeat (4) tick(1'b0, '0);
    reset_now();
    run_job(0);

    run_job(2);
    reset_now();

    min_gap_test();

    repeat (6) run_job(1);

    run_job(3);
    reset_now();
    run_job(0);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
`default_nettype wire
